// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexer / arbiter slice.
package mux_pkg;

  // Channel selection modes
  localparam int MUX_MODE_SEL = 0;  // channel chosen by the external selector
  localparam int MUX_MODE_RR  = 1;  // channel chosen by round-robin arbitration

  // Ceiling log2, used for channel index widths
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping
// around to channel 0. Purely combinational; the pointer lives in the parent.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);

  logic w_found;

  // Two-pass priority search: channels ptr..N-1 first, then 0..ptr-1
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && (k >= int'(ptr)) && req[k]) begin
        w_found  = 1'b1;
        grant[k] = 1'b1;
        idx      = SEL_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && (k < int'(ptr)) && req[k]) begin
        w_found  = 1'b1;
        grant[k] = 1'b1;
        idx      = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N:1 channel multiplexer with a single registered output stage.
// The channel is picked either by an external selector or by a round-robin
// arbiter; the output register accepts a new word whenever it is empty or
// being drained, so back-to-back words flow at one per cycle.
module mux_arb
  import mux_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  N     = 4,
  parameter int  MODE  = MUX_MODE_SEL,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   selector,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan
);

  logic             w_load_en;
  logic             w_xfer;
  logic [N-1:0]     w_grant;
  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_mux_data;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;

  // Output register can take a word when empty or when its word leaves now
  assign w_load_en = !r_out_valid || out_ready;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] r_rr_ptr;
      logic             w_unused_sel;

      assign w_unused_sel = ^selector;

      rr_arbiter #(
        .N    (N),
        .SEL_W(SEL_W)
      ) u_arb (
        .req  (in_valid),
        .ptr  (r_rr_ptr),
        .grant(w_grant),
        .idx  (w_idx)
      );

      // Move the pointer just past the channel that was served
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rr_ptr <= '0;
        end else if (w_xfer) begin
          r_rr_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
      end
    end else begin : g_sel
      // Decode the selector; an out-of-range index grants nothing
      always_comb begin
        w_grant = '0;
        for (int k = 0; k < N; k++) begin
          if (int'(selector) == k) w_grant[k] = 1'b1;
        end
      end

      assign w_idx = selector;
    end
  endgenerate

  // Ready follows the grant only while the output stage can load
  assign in_ready = (reset_n && w_load_en) ? w_grant : '0;
  assign w_xfer   = |(in_ready & in_valid);

  // N:1 data mux steered by the grant index
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx == SEL_W'(k)) w_mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register; data and channel hold their value when nothing loads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_mux_data;
        r_out_chan <= w_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: three instances (select N=4, round-robin N=4,
// select N=3) compared every cycle against a behavioural model, plus
// directed literal expectations.
module tb_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [15:0]   iv   [3];
  logic [3:0]    sel  [3];
  logic [511:0]  din  [3];
  logic          ordy [3];

  logic [3:0]    rdy0, rdy1;
  logic [2:0]    rdy2;
  logic          ov [3];
  logic [31:0]   od [3];
  logic [1:0]    oc [3];

  int n_tests = 0;
  int n_fail  = 0;

  mux_arb #(.WIDTH(32), .N(4), .MODE(0)) u_sel4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0][3:0]), .in_ready(rdy0),
    .in_data(din[0][127:0]), .selector(sel[0][1:0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .out_chan(oc[0]));

  mux_arb #(.WIDTH(32), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1][3:0]), .in_ready(rdy1),
    .in_data(din[1][127:0]), .selector(sel[1][1:0]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .out_chan(oc[1]));

  mux_arb #(.WIDTH(32), .N(3), .MODE(0)) u_sel3 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2][2:0]), .in_ready(rdy2),
    .in_data(din[2][95:0]), .selector(sel[2][1:0]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]), .out_chan(oc[2]));

  function automatic int cfg_mode(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_n(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic logic [15:0] act_rdy(int k);
    case (k)
      0:       return {12'd0, rdy0};
      1:       return {12'd0, rdy1};
      default: return {13'd0, rdy2};
    endcase
  endfunction

  // Behavioural model: output register contents and round-robin pointer
  bit          mv [3] = '{0, 0, 0};
  logic [31:0] md [3] = '{0, 0, 0};
  int          mc [3] = '{0, 0, 0};
  int          mp [3] = '{0, 0, 0};

  // Channel offered the slot this cycle, -1 when none
  function automatic int pick(int k);
    int n, s, c;
    n = cfg_n(k);
    if (cfg_mode(k) == 0) begin
      s = int'(sel[k][1:0]);
      return (s < n) ? s : -1;
    end
    for (int i = 0; i < n; i++) begin
      c = (mp[k] + i) % n;
      if (iv[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_rdy(int k);
    int g;
    g = pick(k);
    if (reset_n !== 1'b1 || g < 0 || !(!mv[k] || ordy[k])) return 16'd0;
    return 16'(1) << g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    int g;
    logic [15:0] r;
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] = 0; md[k] = '0; mc[k] = 0; mp[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        r = exp_rdy(k);
        g = pick(k);
        if (!mv[k] || ordy[k]) begin
          if (g >= 0 && r[g] && iv[k][g]) begin
            mv[k] = 1;
            md[k] = din[k][g*32 +: 32];
            mc[k] = g;
            mp[k] = (g + 1) % cfg_n(k);
          end else begin
            mv[k] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_ready%0d", k), act_rdy(k), exp_rdy(k));
        chk($sformatf("model_valid%0d", k), ov[k], mv[k]);
        chk($sformatf("model_data%0d", k), od[k], md[k]);
        chk($sformatf("model_chan%0d", k), oc[k], mc[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 16'($urandom);
      sel[k]  = 4'($urandom_range(0, 3));
      ordy[k] = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 16; j++) din[k][j*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0; sel[k] = '0; din[k] = '0; ordy[k] = 1'b1;
    end
    iv[0] = 16'h0001; iv[1] = 16'h000F; iv[2] = 16'h0007;

    repeat (2) begin
      @(negedge clk);
      chk("rst_ready0", act_rdy(0), 0);
      chk("rst_ready1", act_rdy(1), 0);
      chk("rst_ready2", act_rdy(2), 0);
      chk("rst_valid0", ov[0], 0);
      chk("rst_valid1", ov[1], 0);
      chk("rst_data0", od[0], 0);
      chk("rst_chan1", oc[1], 0);
    end

    step();
    reset_n = 1'b1;
    sel[0] = 4'd2; iv[0] = 16'h0004; din[0][64 +: 32] = 32'hDEADBEEF; ordy[0] = 1'b1;
    iv[1] = 16'h000F; ordy[1] = 1'b1;
    sel[2] = 4'd3; iv[2] = 16'h0007; ordy[2] = 1'b1;
    @(negedge clk);
    chk("sel_ready", act_rdy(0), 16'h0004);
    chk("rr_first_ready", act_rdy(1), 16'h0001);
    chk("oob_ready", act_rdy(2), 0);
    step();

    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin
        ordy[0] = 1'b0;
        din[0][64 +: 32] = 32'hCAFEF00D;
      end
      if (c == 4) ordy[0] = 1'b1;
      if (c == 5) iv[0] = 16'h0000;
      if (c == 8) iv[1] = 16'h0000;
      @(negedge clk);
      chk("rr_valid", ov[1], 1);
      chk("rr_chan_seq", oc[1], (c - 1) % 4);
      chk("oob_valid", ov[2], 0);
      chk("oob_ready", act_rdy(2), 0);
      if (c <= 3) begin
        chk("stall_valid", ov[0], 1);
        chk("stall_data", od[0], 32'hDEADBEEF);
        chk("stall_chan", oc[0], 2);
        chk("stall_ready", act_rdy(0), 0);
      end
      if (c == 4) begin
        chk("resume_ready", act_rdy(0), 16'h0004);
        chk("resume_old_data", od[0], 32'hDEADBEEF);
      end
      if (c == 5) begin
        chk("nobubble_valid", ov[0], 1);
        chk("nobubble_data", od[0], 32'hCAFEF00D);
      end
      if (c == 6) begin
        chk("drain_valid", ov[0], 0);
        chk("drain_hold_data", od[0], 32'hCAFEF00D);
      end
      step();
    end

    iv[1] = 16'h0001;
    @(negedge clk);
    chk("wrap_pre_ready", act_rdy(1), 16'h0001);
    step();
    iv[1] = 16'h0009;
    @(negedge clk);
    chk("wrap_ready3", act_rdy(1), 16'h0008);
    step();
    @(negedge clk);
    chk("wrap_chan3", oc[1], 3);
    chk("wrap_ready0", act_rdy(1), 16'h0001);
    step();
    @(negedge clk);
    chk("wrap_chan0", oc[1], 0);
    step();

    repeat (400) begin
      rand_inputs();
      step();
    end

    iv[1] = 16'h000F;
    ordy[1] = 1'b0;
    step();
    #1;
    chk("pre_rst_valid", ov[1], 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", ov[1], 0);
    chk("async_rst_data", od[1], 0);
    chk("async_rst_chan", oc[1], 0);
    chk("async_rst_ready", act_rdy(1), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0; ordy[k] = 1'b1;
    end
    @(negedge clk);
    chk("post_rst_valid", ov[1], 0);
    step();
    iv[1] = 16'h0009;
    @(negedge clk);
    chk("post_rst_no_replay", ov[1], 0);
    chk("post_rst_grant", act_rdy(1), 16'h0001);
    step();
    @(negedge clk);
    chk("post_rst_chan", oc[1], 0);
    chk("post_rst_valid_new", ov[1], 1);
    step();

    repeat (200) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
